// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - Shared screen constants, pixel typedefs and scheduler state enum.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [7:0] vga_x_t;
    typedef logic [6:0] vga_y_t;
    typedef logic [2:0] vga_colour_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    function automatic logic on_screen(input vga_x_t x, input vga_y_t y);
        return (x < vga_x_t'(SCREEN_W)) && (y < vga_y_t'(SCREEN_H));
    endfunction

endpackage

// File: rtl/vga_draw_scheduler_if.sv
// rtl/vga_draw_scheduler_if.sv - Engine-side handshake/pixel bus plus adapter-side pixel write.
interface vga_draw_scheduler_if #(
    parameter int NUM_REQ = 3
);
    import vga_pkg::*;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] eng_x;
    logic [NUM_REQ*7-1:0] eng_y;
    logic [NUM_REQ*3-1:0] eng_colour;
    logic [NUM_REQ-1:0]   eng_plot;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   start;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    vga_x_t               vga_x;
    vga_y_t               vga_y;
    vga_colour_t          vga_colour;
    logic                 vga_plot;

    modport master (
        output req, eng_x, eng_y, eng_colour, eng_plot, done,
        input  start, grant, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, eng_x, eng_y, eng_colour, eng_plot, done,
        output start, grant, busy, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/vga_req_picker.sv
// rtl/vga_req_picker.sv - One-hot winner select; VGA_SCHED_RR_EN picks round-robin, else lowest index.
module vga_req_picker #(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
`ifdef VGA_SCHED_RR_EN
    input  logic [PW-1:0]      i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_onehot
);

    logic w_found;

`ifdef VGA_SCHED_RR_EN
    int w_idx;

    // Search begins at the pointer and wraps, so the last-served engine goes to the back.
    always_comb begin
        o_onehot = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_onehot[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end
`else
    always_comb begin
        o_onehot = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req[k]) begin
                o_onehot[k] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/vga_draw_scheduler.sv
// rtl/vga_draw_scheduler.sv - Job-granular owner of the VGA write port; VGA_SCHED_RR_EN selects round-robin.
module vga_draw_scheduler
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    vga_draw_scheduler_if.slave bus
);

    sched_state_t       r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] w_pick;

    vga_x_t      r_vga_x, w_eng_x;
    vga_y_t      r_vga_y, w_eng_y;
    vga_colour_t r_vga_colour, w_eng_colour;
    logic        r_vga_plot, w_plot_nxt;
    logic        w_eng_plot, w_eng_done;

    // Owner's lanes; grant is one-hot so at most one term contributes.
    always_comb begin
        w_eng_x      = '0;
        w_eng_y      = '0;
        w_eng_colour = '0;
        w_eng_plot   = 1'b0;
        w_eng_done   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_eng_x      = bus.eng_x[i*8 +: 8];
                w_eng_y      = bus.eng_y[i*7 +: 7];
                w_eng_colour = bus.eng_colour[i*3 +: 3];
                w_eng_plot   = bus.eng_plot[i];
                w_eng_done   = bus.done[i];
            end
        end
    end

`ifdef VGA_SCHED_RR_EN
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] r_ptr, w_ptr_nxt, w_gidx;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = PW'(i);
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (r_state == DRAIN && !w_eng_done) begin
            w_ptr_nxt = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    vga_req_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick)
    );
`else
    vga_req_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (bus.req),
        .o_onehot (w_pick)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = RUN;
                    w_grant_nxt = w_pick;
                end
            end
            RUN: begin
                if (w_eng_done) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_eng_done) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // The done cycle itself must not plot: the engine may still hold its strobe there.
    assign w_plot_nxt = w_eng_plot && (r_state == RUN) && !w_eng_done
                        && on_screen(w_eng_x, w_eng_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            if (r_state != IDLE) begin
                r_vga_x      <= w_eng_x;
                r_vga_y      <= w_eng_y;
                r_vga_colour <= w_eng_colour;
            end
            r_vga_plot <= w_plot_nxt;
        end
    end

    assign bus.start      = (r_state == RUN) ? r_grant : '0;
    assign bus.grant      = r_grant;
    assign bus.busy       = (r_state != IDLE);
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;

endmodule

// File: doc/vga_draw_scheduler.md
# vga_draw_scheduler

Shares the single VGA adapter write port (vga_x/vga_y/vga_colour/vga_plot) among NUM_REQ drawing engines, such as fillscreen and circle. It grants the port to one engine for the whole of that engine's job and runs a 4-phase start/done handshake with it. It registers the muxed pixel stream toward the adapter and suppresses off-screen plots. The block sits between the engines and the VGA adapter in the top-level.

## Interface
- NUM_REQ, default 3: number of drawing engines, range 2..8.
- clk  in  1: system clock, CLOCK_50 domain.
- rst  in  1: synchronous, active-high reset.
- req  in  NUM_REQ: engine i requests the port; level, held until its job is granted.
- eng_x  in  NUM_REQ×8: packed per-engine x coordinate.
- eng_y  in  NUM_REQ×7: packed per-engine y coordinate.
- eng_colour  in  NUM_REQ×3: packed per-engine colour.
- eng_plot  in  NUM_REQ: per-engine plot strobe.
- done  in  NUM_REQ: engine i finished; held high until its start drops.
- start  out  NUM_REQ: one-hot; high for the granted engine while its job runs.
- grant  out  NUM_REQ: one-hot current owner; 0 when idle.
- busy  out  1: high in RUN or DRAIN.
- vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1: registered pixel write to the adapter.

## Operation
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - grant, start, busy, vga_x, vga_y, vga_colour and vga_plot all go to 0.
  - Round-robin pointer goes to 0.
  - Reset has priority over every transition, including mid-job. The engine sees start fall and must abandon its job.
- IDLE:
  - If req≠0, pick a winner, load grant, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - start=grant.
  - The pixel stream of engine g is forwarded.
  - When done[g]=1, go to DRAIN.
- DRAIN:
  - start=0 and grant is held.
  - Wait for done[g]=0, then go to IDLE, clear grant, and advance the pointer to g+1 mod NUM_REQ.
- Forwarding:
  - Each cycle vga_x/vga_y/vga_colour take eng_*[g]. In IDLE they hold their last value.
  - vga_plot = eng_plot[g] & (state==RUN) & !done[g] & (eng_x[g] < SCREEN_W) & (eng_y[g] < SCREEN_H).
  - Off-screen coordinates (x≥160 or y≥120) never plot.
- Engines that are not granted are ignored: their plot strobes are dropped and their done is ignored.
- If req[g] falls during RUN, the job continues. Only done ends it.
- If req[g] is still high on return to IDLE, it is a new request and arbitrates normally.

## Timing
- Grant latency: req sampled in IDLE at edge N → grant and start high after edge N, i.e. RUN from cycle N+1.
- Pixel latency: eng_* at edge M in RUN → vga_* valid after edge M (1 register stage). Engine plot of cycle k appears on vga_plot in cycle k+1.
- done[g] rising at edge D → DRAIN from D; start low after D. The done cycle itself never plots.
- done[g] falling at edge E in DRAIN → IDLE after E. The earliest next grant is at edge E+1.
- Minimum gap between jobs: 2 idle cycles of vga_plot=0 (DRAIN plus IDLE).
- A full-screen fill at 1 pixel per cycle takes 19200 RUN cycles plus 3 cycles of overhead.

## Configuration
- VGA_SCHED_RR_EN defined: round-robin arbitration.
  - Search starts at the pointer and wraps; the first set req wins.
  - The pointer advances past the served engine on DRAIN→IDLE.
- VGA_SCHED_RR_EN undefined: fixed priority.
  - The lowest set index always wins.
  - The pointer register is not implemented.

## Structure
- vga_pkg holds:
  - SCREEN_W=160 and SCREEN_H=120.
  - Typedefs vga_x_t (logic [7:0]), vga_y_t (logic [6:0]) and vga_colour_t (logic [2:0]).
  - The sched_state_t enum {IDLE, RUN, DRAIN}.
- Sub-module: vga_req_picker, a combinational one-hot winner select (req, pointer → onehot) that contains the VGA_SCHED_RR_EN split.
- Top FSM, output registers and mux live in vga_draw_scheduler.

## Test plan
- Reset check: assert rst for 2 cycles with req=3'b111 → grant=0, start=0, vga_plot=0, busy=0 throughout. Release rst → grant=3'b001 one cycle later.
- Single job: req=3'b010, engine 1 plots (x=5, y=7, colour=5) for 3 cycles then raises done.
  - vga_* = (5, 7, 5), plot=1 for exactly 3 cycles, each 1 cycle delayed.
  - start[1] drops the cycle after done.
  - grant clears the cycle after done falls.
- Contention under round-robin: req=3'b111 held → grants 001, 010, 100, 001 in order. Without the macro → 001 repeatedly.
- Clipping: granted engine drives x=160,y=0 then x=0,y=120 then x=159,y=119, all with plot=1 → vga_plot=0, 0, 1.
- Isolation: engine 2 toggles eng_plot and done while engine 0 owns the port → vga_* reflect only engine 0 and the FSM stays in RUN.
- Reset mid-job: rst in RUN after 10 pixels → next cycle state IDLE, start=0, vga_plot=0. A re-request restarts from grant.
